div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
// Upstream front-end for the iterative divider: accepts operand pairs on a valid/ready
// port, buffers them in a small FIFO and issues them one at a time to the divider via a
// start pulse. Captures quo/rem when the divider raises stop and presents each result on
// a valid/ready output port. Divide-by-zero is resolved locally, and a watchdog prevents
// lock-up if stop never arrives.
// PARAMETERS
// N      4      operand/result width (matches divider N)
// DEPTH  4      operand FIFO entries; power of 2, >=2
// TMO    N+8    watchdog limit in cycles spent in WAIT before an abort is forced
// PORTS
// clk           in   1      clock, all logic on rising edge
// reset         in   1      synchronous reset, active-high
// in_valid      in   1      operand pair valid
// in_ready      out  1      FIFO can accept (= !full)
// in_dividend   in   N      dividend
// in_divisor    in   N      divisor
// div_start     out  1      1-cycle pulse to divider start
// div_dividend  out  N      registered dividend to divider, stable from start to stop
// div_divisor   out  N      registered divisor to divider, stable from start to stop
// div_quo       in   N      divider quotient
// div_rem       in   N      divider remainder
// div_stop      in   1      divider done, sampled only in WAIT
// out_valid     out  1      result valid, held until out_ready
// out_ready     in   1      consumer accepts result
// out_quo       out  N      quotient
// out_rem       out  N      remainder
// out_dbz       out  1      result came from a divisor of 0
// out_tmo       out  1      result is a watchdog abort
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, watchdog = 0. Outputs in_ready=1, div_start=0,
//   div_dividend=div_divisor=0, out_valid=0, out_quo=out_rem=0, out_dbz=out_tmo=0.
// - Reset mid-operation aborts everything. Queued operands and any pending result are
//   lost. The top level resets the divider in the same cycle.
// - Input: push when in_valid&&in_ready. in_ready=!full. A push is refused when the
//   FIFO is full, even if a pop happens in the same cycle. Push and pop together on a
//   non-full, non-empty FIFO are both performed, and the count is unchanged.
// - FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full/empty are decided
//   from the MSB of the pointers.
// - FSM states are IDLE, WAIT, ABORT.
// - IDLE: if FIFO is non-empty and out_valid==0, pop the head entry.
//   - divisor==0: load the output directly with quo={N{1}}, rem=dividend, dbz=1, and
//     stay in IDLE. The divider is not started.
//   - divisor!=0: register the operands onto div_dividend/div_divisor, pulse
//     div_start=1 for exactly 1 cycle, clear the watchdog, and go to WAIT.
// - WAIT: watchdog increments each cycle.
//   - On div_stop=1: capture div_quo/div_rem into the output register, set
//     out_valid=1 on the next cycle, dbz=0, tmo=0, and go to IDLE.
//   - If the watchdog reaches TMO before div_stop: go to ABORT.
// - ABORT: output quo=0, rem=0, tmo=1, out_valid=1, and go to IDLE. A late div_stop in
//   IDLE is ignored.
// - Output: out_valid and the data are held stable until out_valid&&out_ready. A new
//   pop is only allowed with out_valid==0, so there is at most one operation in flight
//   plus one result held.
// - Latency for an empty FIFO, IDLE state and out_ready=1:
//   - in accepted at cycle t, head visible at t+1, div_start at t+2.
//   - out_valid at stop_cycle+1.
//   - a dbz result is out_valid at t+2.
// - Operands are issued in FIFO order, and results are returned in the same order.
// STRUCTURE
// - Shared package div_pkg holds the FSM state enum (IDLE, WAIT, ABORT), the constant
//   DBZ_QUO={N{1}} expressed as a function of N, and the result flag bit positions.
// - One sub-module, div_op_fifo: a synchronous FIFO of width 2N and depth DEPTH, with
//   push/pop/full/empty and data registered at the head.
// - Top-level FSM, watchdog counter and output register live in div_issue_ctrl.
// TESTING (N=4, DEPTH=4; bench divider model asserts stop N+2 cycles after start)
// - 13/3 single op -> one div_start pulse; out_quo=4, out_rem=1, dbz=0, tmo=0.
// - 7/0 -> no div_start; out_quo=4'hF, out_rem=7, out_dbz=1, out_valid at t+2.
// - 5 back-to-back pushes 9/2,15/4,8/8,1/5,6/1 with out_ready=0: in_ready drops after
//   4 accepted pushes. With out_ready=1, results come back in order: (4,1) (3,3) (1,0)
//   (0,1) (6,0).
// - Model never asserts stop for 10/3 -> out_tmo=1, quo=rem=0 after TMO cycles. A stop
//   injected afterwards is ignored, and the next op 12/5 returns (2,2).
// - out_ready held low 20 cycles on the 13/3 result -> out_valid and data stay stable,
//   no further div_start occurs, and the result is accepted when out_ready rises.
// - reset asserted in WAIT with 2 entries queued -> next cycle in_ready=1,
//   out_valid=0, div_start=0, FIFO empty, and no stale result appears later.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue front-end.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package div_pkg;

    // Issue controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

    // Result flag vector layout.
    localparam int FLAG_W   = 2;
    localparam int FLAG_DBZ = 0;
    localparam int FLAG_TMO = 1;

    localparam logic [FLAG_W-1:0] FLAGS_NONE = 2'b00;
    localparam logic [FLAG_W-1:0] FLAGS_DBZ  = 2'b01;
    localparam logic [FLAG_W-1:0] FLAGS_TMO  = 2'b10;

    // Quotient reported for a zero divisor: all ones in the low n bits.
    function automatic logic [31:0] dbz_quo(input int n);
        if (n >= 32) begin
            dbz_quo = '1;
        end else begin
            dbz_quo = (32'd1 << n) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO, W bits wide and DEPTH entries deep, head entry shown on pop_dat.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push ignored while full (even with a simultaneous pop); pop ignored while empty.
//
// Ports: clk, reset (sync, active-high), push/push_dat, pop/pop_dat (head), full, empty.
module div_op_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Front-end for the iterative divider: queues operand pairs, issues one at a time, returns results.
// Latency: push at t -> div_start at t+2 (dbz result valid at t+2); result valid the cycle after div_stop.
// Backpressure: in_ready = FIFO not full; a result is held until out_ready and blocks further issue.
//
// Ports: clk, reset (sync, active-high); in_* operand input port; div_* divider interface;
//        out_* result port with dbz (zero divisor) and tmo (watchdog abort) flags.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int TMO   = N + 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_dividend,
    input  logic [N-1:0] in_divisor,
    output logic         div_start,
    output logic [N-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    input  logic [N-1:0] div_quo,
    input  logic [N-1:0] div_rem,
    input  logic         div_stop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_quo,
    output logic [N-1:0] out_rem,
    output logic         out_dbz,
    output logic         out_tmo
);

    localparam int          WW       = $clog2(TMO + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);
    localparam logic [WW-1:0] WD_ONE  = WW'(1);
    localparam logic [31:0] DBZ_FULL = dbz_quo(N);
    localparam logic [N-1:0] DBZ_QUO = DBZ_FULL[N-1:0];

    state_t              state;
    state_t              state_n;
    logic [WW-1:0]       wdog;
    logic [2*N-1:0]      head;
    logic [N-1:0]        head_dividend;
    logic [N-1:0]        head_divisor;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                issue;
    logic                load_dbz;
    logic                capture;
    logic [FLAG_W-1:0]   out_flags;

    assign in_ready      = !fifo_full;
    assign head_dividend = head[2*N-1:N];
    assign head_divisor  = head[N-1:0];
    assign out_dbz       = out_flags[FLAG_DBZ];
    assign out_tmo       = out_flags[FLAG_TMO];

    div_op_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat ({in_dividend, in_divisor}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A pop is only taken when no result is held, so at most one op is in
    // flight and one result is waiting at any time.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        issue    = 1'b0;
        load_dbz = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    pop = 1'b1;
                    if (head_divisor == '0) begin
                        load_dbz = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (div_stop) begin
                    capture = 1'b1;
                    state_n = IDLE;
                end else if (wdog == WD_LAST) begin
                    state_n = ABORT;
                end
            end
            ABORT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            wdog         <= '0;
            out_valid    <= 1'b0;
            out_quo      <= '0;
            out_rem      <= '0;
            out_flags    <= FLAGS_NONE;
        end else begin
            div_start <= issue;

            // Operands stay registered until the next issue, covering start..stop.
            if (issue) begin
                div_dividend <= head_dividend;
                div_divisor  <= head_divisor;
                wdog         <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + WD_ONE;
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Loads only happen while no result is held, so they never collide
            // with the handshake clear above.
            if (load_dbz) begin
                out_valid <= 1'b1;
                out_quo   <= DBZ_QUO;
                out_rem   <= head_dividend;
                out_flags <= FLAGS_DBZ;
            end else if (capture) begin
                out_valid <= 1'b1;
                out_quo   <= div_quo;
                out_rem   <= div_rem;
                out_flags <= FLAGS_NONE;
            end else if (state == ABORT) begin
                out_valid <= 1'b1;
                out_quo   <= '0;
                out_rem   <= '0;
                out_flags <= FLAGS_TMO;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider that stops N+2 cycles after start.
module tb_div_issue_ctrl;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = N + 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_dividend;
    logic [N-1:0] in_divisor;
    logic         div_start;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic [N-1:0] div_quo;
    logic [N-1:0] div_rem;
    logic         div_stop;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_quo;
    logic [N-1:0] out_rem;
    logic         out_dbz;
    logic         out_tmo;

    int pass_cnt = 0;
    int total    = 0;
    int start_cnt = 0;

    // Divider model controls.
    logic         hang       = 1'b0;
    logic         force_stop = 1'b0;
    logic         model_stop;
    logic         busy;
    logic [3:0]   cnt;

    always #5 clk = ~clk;

    div_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quo      (div_quo),
        .div_rem      (div_rem),
        .div_stop     (div_stop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quo      (out_quo),
        .out_rem      (out_rem),
        .out_dbz      (out_dbz),
        .out_tmo      (out_tmo)
    );

    assign div_stop = model_stop | force_stop;

    // Behavioural divider: stop is high on the sixth cycle after the start cycle.
    always @(posedge clk) begin
        model_stop <= 1'b0;
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (div_start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd4) begin
                busy <= 1'b0;
                if (!hang) begin
                    model_stop <= 1'b1;
                    div_quo    <= div_dividend / div_divisor;
                    div_rem    <= div_dividend % div_divisor;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (div_start) start_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic get_result(input string tag, input logic [N-1:0] q, input logic [N-1:0] r);
        int n;
        wait_valid(n);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_quo"}, out_quo, q);
        check({tag, "_rem"}, out_rem, r);
        check({tag, "_flags"}, {out_dbz, out_tmo}, 2'b00);
        tick();
    endtask

    logic [N-1:0] a_dvd [5] = '{4'd9, 4'd15, 4'd8, 4'd1, 4'd6};
    logic [N-1:0] a_dvs [5] = '{4'd2, 4'd4,  4'd8, 4'd5, 4'd1};
    logic [N-1:0] q_exp [5] = '{4'd4, 4'd3,  4'd1, 4'd0, 4'd6};
    logic [N-1:0] r_exp [5] = '{4'd1, 4'd3,  4'd0, 4'd1, 4'd0};

    initial begin
        int n;
        int s0;
        int vcnt;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_in_ready", in_ready, 1);
        check("rst_div_start", div_start, 0);
        check("rst_div_ops", {div_dividend, div_divisor}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", {out_quo, out_rem}, 0);
        check("rst_out_flags", {out_dbz, out_tmo}, 0);
        reset = 1'b0;
        tick();

        // 13/3 single op.
        s0 = start_cnt;
        drive(4'd13, 4'd3);
        tick();
        in_valid = 1'b0;
        check("op1_no_start_t1", div_start, 0);
        tick();
        check("op1_start_t2", div_start, 1);
        check("op1_div_ops", {div_dividend, div_divisor}, {4'd13, 4'd3});
        wait_valid(n);
        check("op1_latency", n, 7);
        check("op1_quo", out_quo, 4);
        check("op1_rem", out_rem, 1);
        check("op1_flags", {out_dbz, out_tmo}, 2'b00);
        check("op1_one_start", start_cnt - s0, 1);
        tick();
        check("op1_accepted", out_valid, 0);

        // 7/0 resolved locally.
        s0 = start_cnt;
        drive(4'd7, 4'd0);
        tick();
        in_valid = 1'b0;
        check("dbz_not_yet", out_valid, 0);
        tick();
        check("dbz_valid_t2", out_valid, 1);
        check("dbz_quo", out_quo, 4'hF);
        check("dbz_rem", out_rem, 7);
        check("dbz_flags", {out_dbz, out_tmo}, 2'b10);
        tick();
        check("dbz_no_start", start_cnt - s0, 0);
        check("dbz_accepted", out_valid, 0);

        // 13/3 held 20 cycles while 5 pushes arrive; the fifth is refused while full.
        out_ready = 1'b0;
        drive(4'd13, 4'd3);
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check("hold_valid", out_valid, 1);
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            check("hold_stable", {out_valid, out_quo, out_rem}, {1'b1, 4'd4, 4'd1});
            if (i < 4) begin
                check("fill_in_ready", in_ready, 1);
                drive(a_dvd[i], a_dvs[i]);
            end else if (i == 4) begin
                check("full_in_ready", in_ready, 0);
                drive(a_dvd[4], a_dvs[4]);
            end
            tick();
        end
        check("hold_no_start", start_cnt - s0, 0);
        check("hold_full", in_ready, 0);
        out_ready = 1'b1;
        check("hold_res_quo", out_quo, 4);
        check("hold_res_rem", out_rem, 1);
        tick();
        check("full_pop_refuse", in_ready, 0);
        tick();
        check("room_after_pop", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_result($sformatf("order%0d", i), q_exp[i], r_exp[i]);
        end

        // Watchdog abort on 10/3, then a stray stop in IDLE, then 12/5.
        hang = 1'b1;
        drive(4'd10, 4'd3);
        tick();
        in_valid = 1'b0;
        tick();
        check("tmo_start", div_start, 1);
        wait_valid(n);
        check("tmo_latency", n, TMO + 1);
        check("tmo_data", {out_quo, out_rem}, 0);
        check("tmo_flags", {out_dbz, out_tmo}, 2'b01);
        tick();
        check("tmo_accepted", out_valid, 0);
        force_stop = 1'b1;
        tick();
        force_stop = 1'b0;
        check("late_stop_ign1", out_valid, 0);
        tick();
        tick();
        tick();
        check("late_stop_ign2", out_valid, 0);
        hang = 1'b0;
        drive(4'd12, 4'd5);
        tick();
        in_valid = 1'b0;
        get_result("after_tmo", 4'd2, 4'd2);

        // Reset while in WAIT with two entries queued.
        drive(a_dvd[0], a_dvs[0]);
        tick();
        drive(a_dvd[1], a_dvs[1]);
        tick();
        drive(a_dvd[2], a_dvs[2]);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_div_start", div_start, 0);
        check("mrst_div_ops", {div_dividend, div_divisor}, 0);
        reset = 1'b0;
        s0 = start_cnt;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check("mrst_no_stale", vcnt, 0);
        check("mrst_fifo_empty", start_cnt - s0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
